// File: rtl/nombre_scroller.sv
// Scrolling N_DIGITS-wide window over a MSG_LEN-glyph message, driven onto a
// multiplexed common-anode 7-segment display. Define NOMBRE_BLINK_EN to add the blink input.
module nombre_scroller #(
    parameter int N_DIGITS   = 4,
    parameter int MSG_LEN    = 8,
    parameter int MUX_DIV    = 1000,
    parameter int SCROLL_DIV = 5000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       dir,
    input  logic                       char_we,
    input  logic [$clog2(MSG_LEN)-1:0] char_addr,
    input  logic [6:0]                 char_data,
`ifdef NOMBRE_BLINK_EN
    input  logic                       blink,
`endif
    output logic [6:0]                 seg,
    output logic [N_DIGITS-1:0]        an,
    output logic [$clog2(MSG_LEN)-1:0] pos
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [6:0]    BLANK     = 7'h7F;
    localparam logic [AW:0]   MSG_LEN_X = (AW+1)'(MSG_LEN);
    localparam logic [AW-1:0] POS_LAST  = AW'(MSG_LEN - 1);
    localparam logic [DW-1:0] D_LAST    = DW'(N_DIGITS - 1);
    localparam logic [MW-1:0] MC_LAST   = MW'(MUX_DIV - 1);
    localparam logic [SW-1:0] SC_LAST   = SW'(SCROLL_DIV - 1);

    logic [MW-1:0] mc;
    logic [SW-1:0] sc;
    logic [DW-1:0] d;
    logic [6:0]    buffer [MSG_LEN];

    logic          mux_tick;
    logic          step_tick;
    logic          addr_ok;
    logic          blank_out;
    logic [AW:0]   sum;
    logic [AW-1:0] glyph_idx;

    assign mux_tick  = (mc == MC_LAST);
    assign step_tick = (sc == SC_LAST);
    // Compare one bit wider so a power-of-two MSG_LEN does not truncate to zero.
    assign addr_ok   = ({1'b0, char_addr} < MSG_LEN_X);

    // pos < MSG_LEN and d < N_DIGITS <= MSG_LEN, so one subtraction always wraps.
    always_comb begin
        sum       = {1'b0, pos} + (AW+1)'(d);
        glyph_idx = sum[AW-1:0];
        if (sum >= MSG_LEN_X) begin
            glyph_idx = AW'(sum - MSG_LEN_X);
        end
    end

`ifdef NOMBRE_BLINK_EN
    logic phase;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if (step_tick) begin
            phase <= ~phase;
        end
    end

    assign blank_out = blink & phase;
`else
    assign blank_out = 1'b0;
`endif

    // Refresh and step timebases; both free-run regardless of en.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc <= '0;
            sc <= '0;
            d  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values,
            // which lets a refresh tick and a step tick land on the same edge cleanly.
            mc <= mux_tick ? '0 : mc + 1'b1;
            sc <= step_tick ? '0 : sc + 1'b1;
            if (mux_tick) begin
                d <= (d == D_LAST) ? '0 : d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (step_tick && en) begin
            if (!dir) begin
                pos <= (pos == POS_LAST) ? '0 : pos + 1'b1;
            end else begin
                pos <= (pos == '0) ? POS_LAST : pos - 1'b1;
            end
        end
    end

    // NOTE: the glyph buffer is built from flops, not a RAM, because every entry
    // must come out of reset blank; a RAM macro could not be cleared this way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < MSG_LEN; j++) begin
                buffer[j] <= BLANK;
            end
        end else if (char_we && addr_ok) begin
            buffer[char_addr] <= char_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= BLANK;
            an  <= '1;
        end else if (blank_out) begin
            seg <= BLANK;
            an  <= '1;
        end else begin
            seg <= buffer[glyph_idx];
            an  <= ~(N_DIGITS'(1) << d);
        end
    end

endmodule

// File: tb/tb_nombre_scroller.sv
// Directed bench for nombre_scroller with N_DIGITS=4, MSG_LEN=6, MUX_DIV=2, SCROLL_DIV=8.
// k counts rising edges since reset release; outputs after edge k use d = ((k-1)/2) mod 4.
module tb_nombre_scroller;

    localparam int N_DIGITS   = 4;
    localparam int MSG_LEN    = 6;
    localparam int MUX_DIV    = 2;
    localparam int SCROLL_DIV = 8;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       en        = 1'b0;
    logic       dir       = 1'b0;
    logic       char_we   = 1'b0;
    logic [2:0] char_addr = 3'd0;
    logic [6:0] char_data = 7'h00;
`ifdef NOMBRE_BLINK_EN
    logic       blink     = 1'b0;
`endif
    logic [6:0] seg;
    logic [3:0] an;
    logic [2:0] pos;

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;

    nombre_scroller #(
        .N_DIGITS   (N_DIGITS),
        .MSG_LEN    (MSG_LEN),
        .MUX_DIV    (MUX_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .dir       (dir),
        .char_we   (char_we),
        .char_addr (char_addr),
        .char_data (char_data),
`ifdef NOMBRE_BLINK_EN
        .blink     (blink),
`endif
        .seg       (seg),
        .an        (an),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    initial begin
        int blanks;

        // Reset held for 3 edges.
        repeat (3) step();
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an",  32'(an),  32'hF);
        check("rst_pos", 32'(pos), 32'h0);
        rst_n = 1'b1;
        k = 0;
        step();
        check("rel_an",  32'(an),  32'hE);
        check("rel_seg", 32'(seg), 32'h7F);
        check("rel_pos", 32'(pos), 32'h0);

        // Load 0x01..0x06 at edges 2..7, then an out-of-range write at edge 8.
        for (int j = 0; j < MSG_LEN; j++) begin
            char_we   = 1'b1;
            char_addr = 3'(j);
            char_data = 7'(j + 1);
            step();
        end
        char_addr = 3'd7;
        char_data = 7'h00;
        step();
        char_we = 1'b0;

        run_to(9);  check("walk0_an", 32'(an), 32'hE); check("walk0_seg", 32'(seg), 32'h01);
        run_to(11); check("walk1_an", 32'(an), 32'hD); check("walk1_seg", 32'(seg), 32'h02);
        run_to(13); check("walk2_an", 32'(an), 32'hB); check("walk2_seg", 32'(seg), 32'h03);
        run_to(15); check("walk3_an", 32'(an), 32'h7); check("walk3_seg", 32'(seg), 32'h04);
        run_to(16); check("frozen_pos", 32'(pos), 32'h0);

        // Scroll left: ticks at edges 24, 32, ...
        en = 1'b1;
        run_to(23); check("pre_step_pos", 32'(pos), 32'h0);
        run_to(24); check("pos_1", 32'(pos), 32'h1);
        run_to(32); check("pos_2", 32'(pos), 32'h2);
        run_to(40); check("pos_3", 32'(pos), 32'h3);
        run_to(48); check("pos_4", 32'(pos), 32'h4);
        run_to(49); check("p4_d0_an", 32'(an), 32'hE); check("p4_d0_seg", 32'(seg), 32'h05);
        run_to(51); check("p4_d1_an", 32'(an), 32'hD); check("p4_d1_seg", 32'(seg), 32'h06);
        run_to(53); check("p4_d2_an", 32'(an), 32'hB); check("p4_d2_seg", 32'(seg), 32'h01);
        run_to(55); check("p4_d3_an", 32'(an), 32'h7); check("p4_d3_seg", 32'(seg), 32'h02);
        run_to(56); check("pos_5", 32'(pos), 32'h5);
        run_to(64); check("pos_wrap0", 32'(pos), 32'h0);

        // Scroll right from 0, then freeze.
        dir = 1'b1;
        run_to(71); check("dir_no_extra", 32'(pos), 32'h0);
        run_to(72); check("pos_back5", 32'(pos), 32'h5);
        run_to(80); check("pos_back4", 32'(pos), 32'h4);
        en = 1'b0;
        run_to(88); check("hold_pos", 32'(pos), 32'h4);
        run_to(89); check("hold_an0", 32'(an), 32'hE); check("hold_seg0", 32'(seg), 32'h05);
        run_to(91); check("hold_an1", 32'(an), 32'hD);
        run_to(96); check("hold_pos2", 32'(pos), 32'h4);

        // Overwrite the glyph on the active digit (digit 0 -> address 4).
        char_we   = 1'b1;
        char_addr = 3'd4;
        char_data = 7'h40;
        step();
        char_we = 1'b0;
        check("wr_old_seg", 32'(seg), 32'h05);
        check("wr_old_an",  32'(an),  32'hE);
        step();
        check("wr_new_seg", 32'(seg), 32'h40);

`ifdef NOMBRE_BLINK_EN
        // Phase is 0 after 12 ticks; tick at edge 104 sets it, edge 112 clears it.
        blink = 1'b1;
        run_to(104); check("blink_pre_an",  32'(an),  32'h7);
        run_to(105); check("blink_on_an",   32'(an),  32'hF); check("blink_on_seg", 32'(seg), 32'h7F);
        run_to(112); check("blink_end_an",  32'(an),  32'hF);
        run_to(113); check("blink_off_an",  32'(an),  32'hE); check("blink_off_seg", 32'(seg), 32'h40);
        blink = 1'b0;
`else
        // No blink port: the display never blanks across two full step periods.
        blanks = 0;
        for (int j = 0; j < 2 * SCROLL_DIV; j++) begin
            step();
            if (an === 4'hF) blanks++;
        end
        check("no_blink_blanks", 32'(blanks), 32'h0);
`endif

        // Mid-run reset overrides a simultaneous write to address 0.
        rst_n     = 1'b0;
        char_we   = 1'b1;
        char_addr = 3'd0;
        char_data = 7'h00;
        step();
        check("midrst_an",  32'(an),  32'hF);
        check("midrst_seg", 32'(seg), 32'h7F);
        check("midrst_pos", 32'(pos), 32'h0);
        rst_n   = 1'b1;
        char_we = 1'b0;
        k = 0;
        step();
        check("postrst_an",  32'(an),  32'hE);
        check("postrst_seg", 32'(seg), 32'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
